sdram_slot_arbiter: RTL

SDRAM_SLOT_ARBITER -- requirements
Module: sdram_slot_arbiter

---
 rtl/sdram_slot_arbiter_if.sv | 40 ++++
 rtl/sdram_slot_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sdram_slot_arbiter_if.sv
// Bus bundle between the slot arbiter and its clients (video, CPU, loader, SDRAM controller).
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface sdram_slot_arbiter_if #(
    parameter int ADDR_W = 25
);
    logic              mem_sync;
    logic              phi0;
    logic [ADDR_W-1:0] vid_adr;
    logic [ADDR_W-1:0] cpu_adr;
    logic              cpu_we;
    logic [7:0]        cpu_di;
    logic              ldr_active;
    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_adr;
    logic [7:0]        ldr_di;
    logic              ldr_busy;
    logic              ldr_drop;
    logic [ADDR_W-1:0] sdram_adr;
    logic              sdram_we;
    logic [7:0]        sdram_di;
    logic [7:0]        sdram_do;
    logic [7:0]        vid_do;
    logic [7:0]        cpu_do;
    logic [1:0]        slot;
    logic              sync_err;

    modport slave (
        input  mem_sync, phi0, vid_adr, cpu_adr, cpu_we, cpu_di,
        input  ldr_active, ldr_req, ldr_adr, ldr_di, sdram_do,
        output ldr_busy, ldr_drop, sdram_adr, sdram_we, sdram_di,
        output vid_do, cpu_do, slot, sync_err
    );

    modport master (
        output mem_sync, phi0, vid_adr, cpu_adr, cpu_we, cpu_di,
        output ldr_active, ldr_req, ldr_adr, ldr_di, sdram_do,
        input  ldr_busy, ldr_drop, sdram_adr, sdram_we, sdram_di,
        input  vid_do, cpu_do, slot, sync_err
    );
endinterface

// File: rtl/sdram_slot_arbiter.sv
// Time-slot SDRAM arbiter: assigns each mem_sync slot to video, CPU or a one-entry
// loader write buffer, latches read data one slot later and watches for lost mem_sync.
module sdram_slot_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int SYNC_TIMEOUT = 63
) (
    input  logic               clk_48m,
    input  logic               reset,
    sdram_slot_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        SLOT_IDLE = 2'b00,
        SLOT_VID  = 2'b01,
        SLOT_CPU  = 2'b10,
        SLOT_LDR  = 2'b11
    } slot_t;

    localparam logic [5:0] TO_LIM = 6'(SYNC_TIMEOUT - 1);

    slot_t             slot_r;
    slot_t             slot_nxt_s;
    logic [ADDR_W-1:0] sdram_adr_r;
    logic [ADDR_W-1:0] adr_nxt_s;
    logic              sdram_we_r;
    logic              we_nxt_s;
    logic [7:0]        sdram_di_r;
    logic [7:0]        di_nxt_s;
    logic [7:0]        vid_do_r;
    logic [7:0]        cpu_do_r;
    logic              ldr_busy_r;
    logic              ldr_drop_r;
    logic [ADDR_W-1:0] buf_adr_r;
    logic [7:0]        buf_di_r;
    logic              ldr_take_s;
    logic [5:0]        cnt_r;
    logic              timeout_s;
    logic              sync_err_r;

    // Counter was cleared at the last mem_sync; one more clock without it is a timeout.
    assign timeout_s = !bus.mem_sync && (cnt_r >= TO_LIM);

    // Slot decision and the registered SDRAM command for the coming slot.
    always_comb begin
        slot_nxt_s = slot_r;
        adr_nxt_s  = sdram_adr_r;
        we_nxt_s   = sdram_we_r;
        di_nxt_s   = sdram_di_r;
        ldr_take_s = 1'b0;
        if (timeout_s) begin
            slot_nxt_s = SLOT_IDLE;
            we_nxt_s   = 1'b0;
        end else if (bus.mem_sync) begin
            // A pending loader write wins the CPU phase even after ldr_active drops.
            if (!bus.phi0) begin
                slot_nxt_s = SLOT_VID;
            end else if (ldr_busy_r) begin
                slot_nxt_s = SLOT_LDR;
            end else if (bus.ldr_active) begin
                slot_nxt_s = SLOT_IDLE;
            end else begin
                slot_nxt_s = SLOT_CPU;
            end
            case (slot_nxt_s)
                SLOT_VID: begin
                    adr_nxt_s = bus.vid_adr;
                    we_nxt_s  = 1'b0;
                end
                SLOT_CPU: begin
                    adr_nxt_s = bus.cpu_adr;
                    we_nxt_s  = bus.cpu_we;
                    di_nxt_s  = bus.cpu_di;
                end
                SLOT_LDR: begin
                    adr_nxt_s  = buf_adr_r;
                    di_nxt_s   = buf_di_r;
                    we_nxt_s   = 1'b1;
                    ldr_take_s = 1'b1;
                end
                SLOT_IDLE: begin
                    we_nxt_s = 1'b0;
                end
                default: begin
                    slot_nxt_s = SLOT_IDLE;
                    we_nxt_s   = 1'b0;
                end
            endcase
        end else begin
            slot_nxt_s = slot_r;
        end
    end

    // Slot state and SDRAM command registers.
    always_ff @(posedge clk_48m or posedge reset) begin
        if (reset) begin
            slot_r      <= SLOT_IDLE;
            sdram_adr_r <= {ADDR_W{1'b0}};
            sdram_we_r  <= 1'b0;
            sdram_di_r  <= 8'h00;
        end else begin
            slot_r      <= slot_nxt_s;
            sdram_adr_r <= adr_nxt_s;
            sdram_we_r  <= we_nxt_s;
            sdram_di_r  <= di_nxt_s;
        end
    end

    // Read data of the slot that is ending is valid at the next mem_sync.
    always_ff @(posedge clk_48m or posedge reset) begin
        if (reset) begin
            vid_do_r <= 8'h00;
            cpu_do_r <= 8'h00;
        end else if (bus.mem_sync) begin
            if (slot_r == SLOT_VID) begin
                vid_do_r <= bus.sdram_do;
            end else if ((slot_r == SLOT_CPU) && !sdram_we_r) begin
                cpu_do_r <= bus.sdram_do;
            end
        end
    end

    // One-entry loader buffer; a request against a full buffer is dropped, never queued.
    always_ff @(posedge clk_48m or posedge reset) begin
        if (reset) begin
            ldr_busy_r <= 1'b0;
            ldr_drop_r <= 1'b0;
            buf_adr_r  <= {ADDR_W{1'b0}};
            buf_di_r   <= 8'h00;
        end else begin
            ldr_drop_r <= bus.ldr_req && ldr_busy_r;
            if (ldr_take_s) begin
                ldr_busy_r <= 1'b0;
            end else if (bus.ldr_req && !ldr_busy_r) begin
                ldr_busy_r <= 1'b1;
                buf_adr_r  <= bus.ldr_adr;
                buf_di_r   <= bus.ldr_di;
            end
        end
    end

    // mem_sync watchdog; sync_err is sticky until reset.
    always_ff @(posedge clk_48m or posedge reset) begin
        if (reset) begin
            cnt_r      <= 6'd0;
            sync_err_r <= 1'b0;
        end else begin
            if (bus.mem_sync) begin
                cnt_r <= 6'd0;
            end else if (cnt_r != 6'h3F) begin
                cnt_r <= cnt_r + 6'd1;
            end
            if (timeout_s) begin
                sync_err_r <= 1'b1;
            end
        end
    end

    assign bus.slot      = slot_r;
    assign bus.sdram_adr = sdram_adr_r;
    assign bus.sdram_we  = sdram_we_r;
    assign bus.sdram_di  = sdram_di_r;
    assign bus.vid_do    = vid_do_r;
    assign bus.cpu_do    = cpu_do_r;
    assign bus.ldr_busy  = ldr_busy_r;
    assign bus.ldr_drop  = ldr_drop_r;
    assign bus.sync_err  = sync_err_r;
endmodule
